// File: rtl/bp_tlb_sa.sv
// bp_tlb_sa: set-associative ASID-tagged TLB with global pages, deterministic fill replacement and a set-walking flush engine.
// Optional feature: define BP_TLB_SA_PERF_EN to add saturating hit/miss lookup counters.
module bp_tlb_sa #(
   parameter int sets_p        = 4,
   parameter int ways_p        = 2,
   parameter int vtag_width_p  = 27,
   parameter int ptag_width_p  = 28,
   parameter int asid_width_p  = 8,
   parameter int entry_width_p = 36
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     translation_en_i,
   input  logic [asid_width_p-1:0]  asid_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [vtag_width_p-1:0]  vtag_i,
   input  logic [entry_width_p-1:0] entry_i,
   input  logic                     g_i,
   input  logic                     flush_v_i,
   input  logic                     flush_asid_only_i,
   input  logic [asid_width_p-1:0]  flush_asid_i,
   output logic                     ready_o,
   output logic                     v_o,
   output logic [entry_width_p-1:0] entry_o,
   output logic                     miss_v_o,
   output logic [vtag_width_p-1:0]  miss_vtag_o
`ifdef BP_TLB_SA_PERF_EN
   ,
   output logic [31:0]              hit_count_o,
   output logic [31:0]              miss_count_o
`endif
);
   localparam int idx_w_lp = (sets_p > 1) ? $clog2(sets_p) : 1;
   localparam int way_w_lp = (ways_p > 1) ? $clog2(ways_p) : 1;

   typedef enum logic {IDLE, FLUSH} state_e;

   logic [ways_p-1:0]        valid_q [sets_p];
   logic                     g_q     [sets_p][ways_p];
   logic [asid_width_p-1:0]  asid_q  [sets_p][ways_p];
   logic [vtag_width_p-1:0]  tag_q   [sets_p][ways_p];
   logic [entry_width_p-1:0] data_q  [sets_p][ways_p];
   logic [way_w_lp-1:0]      rr_q    [sets_p];

   state_e                   state_q;
   logic [idx_w_lp-1:0]      cnt_q;
   logic                     fl_asid_only_q;
   logic [asid_width_p-1:0]  fl_asid_q;
   logic                     v_q, miss_q;
   logic [entry_width_p-1:0] entry_q;
   logic [vtag_width_p-1:0]  miss_vtag_q;

   logic [idx_w_lp-1:0]      idx;
   logic                     ready, flush_acc, lookup, fill;
   logic [ways_p-1:0]        hit;
   logic                     any_hit, evict;
   logic [way_w_lp-1:0]      hit_way, inv_way, fill_way;
   logic [entry_width_p-1:0] hit_entry, pass_entry;

   assign idx        = (sets_p > 1) ? idx_w_lp'(vtag_i) : '0;
   assign ready      = (state_q == IDLE);
   assign flush_acc  = flush_v_i & ready;
   assign lookup     = v_i & ready & ~flush_v_i & ~w_i;
   assign fill       = v_i & ready & ~flush_v_i & w_i & translation_en_i;
   assign pass_entry = entry_width_p'(ptag_width_p'(vtag_i));

   assign ready_o     = ready;
   assign v_o         = v_q;
   assign miss_v_o    = miss_q;
   assign entry_o     = entry_q;
   assign miss_vtag_o = miss_vtag_q;

   // Tag match in the indexed set; lowest hitting/invalid way wins, else round-robin victim
   always_comb begin
      hit       = '0;
      hit_way   = '0;
      inv_way   = '0;
      hit_entry = '0;
      for (int w = ways_p - 1; w >= 0; w--) begin
         hit[w] = valid_q[idx][w] & (tag_q[idx][w] == vtag_i) & (g_q[idx][w] | (asid_q[idx][w] == asid_i));
         if (hit[w]) begin
            hit_way   = way_w_lp'(w);
            hit_entry = data_q[idx][w];
         end
         if (!valid_q[idx][w]) inv_way = way_w_lp'(w);
      end
      any_hit  = |hit;
      evict    = ~any_hit & (&valid_q[idx]);
      fill_way = any_hit ? hit_way : evict ? rr_q[idx] : inv_way;
   end

   // Entry payload storage; only valid bits need reset
   always_ff @(posedge clk_i) begin
      if (fill) begin
         tag_q[idx][fill_way]  <= vtag_i;
         asid_q[idx][fill_way] <= asid_i;
         g_q[idx][fill_way]    <= g_i;
         data_q[idx][fill_way] <= entry_i;
      end
   end

   // Valid bits, replacement pointers, flush FSM and registered lookup results
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int s = 0; s < sets_p; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
         state_q        <= IDLE;
         cnt_q          <= '0;
         fl_asid_only_q <= 1'b0;
         fl_asid_q      <= '0;
         v_q            <= 1'b0;
         miss_q         <= 1'b0;
         entry_q        <= '0;
         miss_vtag_q    <= '0;
      end else begin
         v_q    <= lookup & (~translation_en_i | any_hit);
         miss_q <= lookup & translation_en_i & ~any_hit;
         if (lookup) begin
            miss_vtag_q <= vtag_i;
            entry_q     <= translation_en_i ? hit_entry : pass_entry;
         end
         if (fill) begin
            valid_q[idx][fill_way] <= 1'b1;
            if (evict) rr_q[idx] <= (rr_q[idx] == way_w_lp'(ways_p - 1)) ? '0 : rr_q[idx] + 1'b1;
         end
         if (state_q == IDLE) begin
            if (flush_acc) begin
               state_q        <= FLUSH;
               cnt_q          <= '0;
               fl_asid_only_q <= flush_asid_only_i;
               fl_asid_q      <= flush_asid_i;
            end
         end else begin
            for (int w = 0; w < ways_p; w++)
               if (~fl_asid_only_q | (~g_q[cnt_q][w] & (asid_q[cnt_q][w] == fl_asid_q)))
                  valid_q[cnt_q][w] <= 1'b0;
            if (~fl_asid_only_q) rr_q[cnt_q] <= '0;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == idx_w_lp'(sets_p - 1)) state_q <= IDLE;
         end
      end
   end

`ifdef BP_TLB_SA_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;

   // Saturating counts of accepted lookups, passthrough lookups counting as hits
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (lookup & (~translation_en_i | any_hit) & (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 1'b1;
         if (lookup & translation_en_i & ~any_hit & (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bp_tlb_sa.sv
// tb_bp_tlb_sa: table-driven and sequence checks of bp_tlb_sa with a result scoreboard.
module tb_bp_tlb_sa;
   logic        clk_i = 1'b0;
   logic        reset_i, translation_en_i, v_i, w_i, g_i, flush_v_i, flush_asid_only_i;
   logic [7:0]  asid_i, flush_asid_i;
   logic [26:0] vtag_i, miss_vtag_o;
   logic [35:0] entry_i, entry_o;
   logic        ready_o, v_o, miss_v_o;
`ifdef BP_TLB_SA_PERF_EN
   logic [31:0] hit_count_o, miss_count_o;
`endif

   bp_tlb_sa dut (
      .clk_i(clk_i), .reset_i(reset_i), .translation_en_i(translation_en_i), .asid_i(asid_i),
      .v_i(v_i), .w_i(w_i), .vtag_i(vtag_i), .entry_i(entry_i), .g_i(g_i),
      .flush_v_i(flush_v_i), .flush_asid_only_i(flush_asid_only_i), .flush_asid_i(flush_asid_i),
      .ready_o(ready_o), .v_o(v_o), .entry_o(entry_o), .miss_v_o(miss_v_o), .miss_vtag_o(miss_vtag_o)
`ifdef BP_TLB_SA_PERF_EN
      , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        hit;
      logic [35:0] entry;
      logic [26:0] vtag;
   } exp_t;

   typedef struct {
      int          op;
      logic        en;
      logic [7:0]  asid;
      logic [26:0] vtag;
      logic [35:0] e;
      logic        g;
      logic        hit;
      logic [35:0] xe;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(int op, logic en, logic [7:0] a, logic [26:0] vt, logic [35:0] e,
                               logic g, logic hit, logic [35:0] xe);
      vec_t r;
      r.op = op; r.en = en; r.asid = a; r.vtag = vt; r.e = e; r.g = g; r.hit = hit; r.xe = xe;
      return r;
   endfunction

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, act, exp);
      end
   endtask

   task automatic cyc();
      exp_t x;
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) chk("no_spurious_out", {62'd0, v_o, miss_v_o}, 64'd0);
      else begin
         x = sb.pop_front();
         chk("v_o", {63'd0, v_o}, {63'd0, x.hit});
         chk("miss_v_o", {63'd0, miss_v_o}, {63'd0, !x.hit});
         chk("miss_vtag_o", {37'd0, miss_vtag_o}, {37'd0, x.vtag});
         if (x.hit) chk("entry_o", {28'd0, entry_o}, {28'd0, x.entry});
      end
      v_i = 1'b0;
      w_i = 1'b0;
      flush_v_i = 1'b0;
   endtask

   task automatic lookup(logic en, logic [7:0] a, logic [26:0] vt, logic hit, logic [35:0] xe);
      exp_t x;
      translation_en_i = en; asid_i = a; vtag_i = vt; v_i = 1'b1; w_i = 1'b0;
      x.hit = hit; x.entry = xe; x.vtag = vt;
      sb.push_back(x);
      cyc();
   endtask

   task automatic fill(logic en, logic [7:0] a, logic [26:0] vt, logic [35:0] e, logic g);
      translation_en_i = en; asid_i = a; vtag_i = vt; entry_i = e; g_i = g; v_i = 1'b1; w_i = 1'b1;
      cyc();
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      cyc();
      reset_i = 1'b0;
   endtask

   task automatic wait_ready(int exp_busy, string n);
      int busy = 0;
      while (!ready_o && busy < 20) begin
         cyc();
         busy++;
      end
      chk(n, 64'(busy), 64'(exp_busy));
   endtask

   task automatic flush(logic asid_only, logic [7:0] a);
      flush_v_i = 1'b1; flush_asid_only_i = asid_only; flush_asid_i = a;
      cyc();
      chk("ready_low_after_flush", {63'd0, ready_o}, 64'd0);
      wait_ready(4, "flush_busy_cycles");
   endtask

   initial begin
      reset_i = 1'b1; translation_en_i = 1'b1; v_i = 1'b0; w_i = 1'b0; g_i = 1'b0;
      flush_v_i = 1'b0; flush_asid_only_i = 1'b0; asid_i = '0; flush_asid_i = '0;
      vtag_i = '0; entry_i = '0;
      cyc();
      cyc();
      reset_i = 1'b0;
      chk("reset_ready_o", {63'd0, ready_o}, 64'd1);
      chk("reset_v_o", {63'd0, v_o}, 64'd0);
      chk("reset_miss_v_o", {63'd0, miss_v_o}, 64'd0);
      chk("reset_miss_vtag_o", {37'd0, miss_vtag_o}, 64'd0);
      chk("reset_entry_o", {28'd0, entry_o}, 64'd0);

      tbl.push_back(mk(0, 1, 0, 27'h10, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 3, 27'h10, 36'h8_0000_0ABC, 0, 0, 0));
      tbl.push_back(mk(0, 1, 3, 27'h10, 0, 0, 1, 36'h8_0000_0ABC));
      tbl.push_back(mk(0, 1, 4, 27'h10, 0, 0, 0, 0));
      tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 27'h0, 36'h100, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 27'h4, 36'h104, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 27'h8, 36'h108, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h4, 0, 0, 1, 36'h104));
      tbl.push_back(mk(0, 1, 1, 27'h8, 0, 0, 1, 36'h108));
      tbl.push_back(mk(1, 1, 1, 27'h4, 36'h55, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h4, 0, 0, 1, 36'h55));
      tbl.push_back(mk(0, 1, 1, 27'h8, 0, 0, 1, 36'h108));
      tbl.push_back(mk(1, 1, 1, 27'hC, 36'h10C, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h4, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h8, 0, 0, 1, 36'h108));
      tbl.push_back(mk(0, 1, 1, 27'hC, 0, 0, 1, 36'h10C));
      tbl.push_back(mk(1, 1, 1, 27'h11, 36'h311, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h11, 0, 0, 1, 36'h311));
      tbl.push_back(mk(0, 1, 1, 27'hC, 0, 0, 1, 36'h10C));
      tbl.push_back(mk(0, 0, 1, 27'h123, 0, 0, 1, 36'h123));
      tbl.push_back(mk(0, 0, 1, 27'h7FF_FFFF, 0, 0, 1, 36'h7FF_FFFF));
      tbl.push_back(mk(1, 0, 1, 27'h21, 36'h777, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 27'h21, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         if (tbl[i].op == 2) do_reset();
         else if (tbl[i].op == 1) fill(tbl[i].en, tbl[i].asid, tbl[i].vtag, tbl[i].e, tbl[i].g);
         else lookup(tbl[i].en, tbl[i].asid, tbl[i].vtag, tbl[i].hit, tbl[i].xe);
      end

      do_reset();
      fill(1, 3, 27'h1, 36'h201, 0);
      fill(1, 3, 27'h2, 36'h202, 1);
      fill(1, 5, 27'h3, 36'h203, 0);
      flush(1, 3);
      lookup(1, 3, 27'h1, 0, 0);
      lookup(1, 3, 27'h2, 1, 36'h202);
      lookup(1, 9, 27'h2, 1, 36'h202);
      lookup(1, 5, 27'h3, 1, 36'h203);

      translation_en_i = 1'b0; v_i = 1'b1; w_i = 1'b0; vtag_i = 27'h5;
      flush_v_i = 1'b1; flush_asid_only_i = 1'b0;
      cyc();
      chk("collision_ready_low", {63'd0, ready_o}, 64'd0);
      translation_en_i = 1'b1; asid_i = 8'd5; vtag_i = 27'h3; v_i = 1'b1; w_i = 1'b0;
      cyc();
      vtag_i = 27'h9; entry_i = 36'h999; v_i = 1'b1; w_i = 1'b1; g_i = 1'b1;
      cyc();
      wait_ready(2, "collision_flush_busy");
      lookup(1, 5, 27'h3, 0, 0);
      lookup(1, 0, 27'h9, 0, 0);

      fill(1, 2, 27'h6, 36'h606, 1);
      lookup(1, 2, 27'h6, 1, 36'h606);
      flush_v_i = 1'b1; flush_asid_only_i = 1'b1; flush_asid_i = 8'd7;
      cyc();
      do_reset();
      chk("ready_after_reset_mid_flush", {63'd0, ready_o}, 64'd1);
      lookup(1, 2, 27'h6, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bp_tlb_sa.md
Name: bp_tlb_sa

Overview:
Parametrised set-associative TLB, the next generation of the fully-associative CAM TLB. It is used by both I-side and D-side.
- Adds ASID-tagged entries and global pages.
- Adds deterministic fill replacement: overwrite-on-hit, else first-invalid, else per-set round-robin.
- Adds a multi-cycle flush engine (all, or per-ASID) that walks sets one per cycle and backpressures lookups.
- Sits between the address generator and the cache tag lookup. The PTW fills it on a miss.

Parameters:
sets_p, 4, number of sets; power of 2, >=1
ways_p, 2, ways per set; >=1
vtag_width_p, 27, virtual tag width; must be >= clog2(sets_p)
ptag_width_p, 28, physical tag width, stored in entry bits [ptag_width_p-1:0]
asid_width_p, 8, ASID width
entry_width_p, 36, opaque entry width; must be >= ptag_width_p

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
translation_en_i  in  1  0 = passthrough mode
asid_i  in  asid_width_p  current ASID, used for lookups and fills
v_i  in  1  request valid; accepted only when ready_o=1
w_i  in  1  1 = fill, 0 = lookup
vtag_i  in  vtag_width_p  request vtag
entry_i  in  entry_width_p  fill data
g_i  in  1  fill is a global page
flush_v_i  in  1  flush request; accepted only when ready_o=1
flush_asid_only_i  in  1  1 = flush non-global entries of flush_asid_i only; 0 = flush all
flush_asid_i  in  asid_width_p  ASID to flush
ready_o  out  1  block idle
v_o  out  1  lookup hit, registered
entry_o  out  entry_width_p  hit entry, valid when v_o=1
miss_v_o  out  1  lookup miss, registered
miss_vtag_o  out  vtag_width_p  vtag of the last accepted lookup

Behaviour:
Reset:
- Clears all valid bits and round-robin pointers.
- FSM goes to IDLE.
- Outputs after reset: ready_o=1, v_o=0, miss_v_o=0, miss_vtag_o=0, entry_o=0.
- Reset mid-flush aborts the walk; all entries end up invalid.

Indexing and hit rule:
- Set index = vtag_i[clog2(sets_p)-1:0]. For sets_p=1 the index is 0.
- The full vtag is stored.
- Hit = valid & (tag==vtag_i) & (g | asid==asid_i).

Lookup (v_i & ~w_i & ready_o):
- Result appears the next cycle: exactly one of v_o / miss_v_o is high for one cycle.
- miss_vtag_o is captured on every accepted lookup.
- entry_o holds the hitting entry and keeps its value until the next accepted lookup.
- translation_en_i=0: lookups always hit. entry_o = passthrough: bits [ptag_width_p-1:0] = vtag zero-extended or truncated; all other bits 0.
- Fills are ignored while translation_en_i=0.

Fill (v_i & w_i & ready_o & translation_en_i):
- Written at the clock edge; no output pulse.
- Way selection, in priority order:
  1. A way that already hits, under the fill's ASID/g rule → overwrite it (no duplicates).
  2. Otherwise the lowest-index invalid way.
  3. Otherwise the way at the set's round-robin pointer; the pointer then increments modulo ways_p.
- The pointer changes only on a victim eviction.
- A lookup in the cycle after a fill sees the new entry.

Flush FSM, states IDLE and FLUSH:
- IDLE→FLUSH on flush_v_i & ready_o. Mode and ASID are latched; the set counter is cleared.
- In FLUSH, one set per cycle:
  - Flush-all clears every way.
  - ASID flush clears ways with valid & ~g & asid==latched ASID.
- FLUSH→IDLE after set sets_p-1, so a flush takes exactly sets_p cycles.
- ready_o=0 throughout FLUSH.
- Round-robin pointers are reset by flush-all only.
- flush_v_i and v_i in the same cycle: flush wins; the request is dropped and produces no v_o/miss_v_o.
- v_i, w_i and flush_v_i with ready_o=0 are ignored.
- A lookup result already registered before the flush was accepted still appears in the cycle after acceptance.

Optional Feature:
BP_TLB_SA_PERF_EN
- Defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0].
  - They count accepted lookups that hit or miss, including passthrough hits.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on reset_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then lookup vtag=0x10 with translation_en_i=1 → next cycle miss_v_o=1, v_o=0, miss_vtag_o=0x10.
2. Fill vtag=0x10, asid=3, ptag=0xABC, g=0; lookup 0x10 with asid 3 → v_o=1, entry_o[27:0]=0xABC. Same lookup with asid 4 → miss_v_o=1.
3. sets_p=4, ways_p=2: fill vtags 0x0, 0x4, 0x8 (all set 0) → 0x8 evicts way 0 (holding 0x0). Lookups: 0x0 misses; 0x4 and 0x8 hit. A 4th fill 0xC evicts way 1 (holding 0x4).
4. Refill vtag 0x4 with new ptag 0x55 → same way is overwritten; lookup returns 0x55; no eviction of 0x8.
5. Fill 0x1 asid=3 g=0, 0x2 asid=3 g=1, 0x3 asid=5. ASID flush of 3 → ready_o=0 for exactly 4 cycles. Afterwards 0x1 misses; 0x2 (global) and 0x3 hit.
6. translation_en_i=0, lookup vtag=0x123 → v_o=1, entry_o=0x123. Also assert flush_v_i and v_i together → no v_o/miss_v_o from the dropped request; ready_o falls next cycle.
